// File: rtl/stack_ctrl_if.sv
// Request/response channel between a sequencer (master) and stack_ctrl (slave).
// A beat transfers on a rising edge where valid && ready are both 1; the sender
// keeps valid and its payload stable until that edge, and ready may not depend on a future valid.
interface stack_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Request-side controller for the stack: owns the stack pointer, sequences push/pop
// strobes into the stack and returns one response per accepted request.
module stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  stack_ctrl_if.slave      bus,
  output logic [DEPTH-1:0] count,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [DEPTH-1:0] stk_pointer,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PUSH = 3'd1;
  localparam logic [2:0] S_POP  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [DEPTH-1:0] SP_ONE  = DEPTH'(1);
  localparam logic [DEPTH-1:0] SP_TWO  = DEPTH'(2);
  localparam logic [DEPTH-1:0] SP_FULL = DEPTH'(DEPTH);

  logic [2:0]       state_q, state_d;
  logic [DEPTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty;

  // Occupancy is tracked locally; the stack's own flags are never consulted.
  assign full  = (sp_q == SP_FULL);
  assign empty = (sp_q == '0);

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op) begin
            if (full) begin
              ovf_d      = 1'b1;
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
              state_d    = S_RESP;
            end else begin
              data_d  = bus.req_data;
              state_d = S_PUSH;
            end
          end else begin
            if (empty) begin
              unf_d      = 1'b1;
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
              state_d    = S_RESP;
            end else begin
              state_d = S_POP;
            end
          end
        end
      end
      S_PUSH: begin
        sp_d       = sp_q + SP_ONE;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
        state_d    = S_RESP;
      end
      S_POP: begin
        sp_d    = sp_q - SP_ONE;
        state_d = S_CAPT;
      end
      // The stack registered its read during POP, so data_out is valid now.
      S_CAPT: begin
        rsp_data_d = stk_data_out;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = (state_q == S_RESP) ? rsp_data_q : '0;
  assign bus.rsp_err   = (state_q == S_RESP) ? rsp_err_q : 1'b0;

  assign stk_push    = (state_q == S_PUSH);
  assign stk_pop     = (state_q == S_POP);
  // The stack reads entry pointer+1 on pop, so point one below the top entry.
  assign stk_pointer = (state_q == S_POP) ? (sp_q - SP_TWO) : sp_q;
  assign stk_data_in = (state_q == S_PUSH) ? data_q : '0;

  assign count      = sp_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with DEPTH=2 and a behavioural stack model.
module tb_stack_ctrl;

  localparam int W = 8;
  localparam int D = 2;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CAPT = 3'd3;

  logic         clk;
  logic         rst;
  logic [D-1:0] count;
  logic         ovf_sticky, unf_sticky;
  logic         stk_push, stk_pop;
  logic [D-1:0] stk_pointer;
  logic [W-1:0] stk_data_in, stk_data_out;
  logic [2:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  stack_ctrl_if #(.WIDTH(W)) bus ();

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .ovf_sticky   (ovf_sticky),
    .unf_sticky   (unf_sticky),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_pointer  (stk_pointer),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stack model: write at pointer on push, registered read of pointer+1 on pop
  logic [W-1:0] mem [4];
  logic [D-1:0] rd_idx;
  assign rd_idx = stk_pointer + 2'd1;
  always @(posedge clk) begin
    if (stk_push) mem[stk_pointer] <= stk_data_in;
    if (stk_pop)  stk_data_out <= mem[rd_idx];
  end

  // strobe monitor
  int           push_cnt = 0;
  int           pop_cnt  = 0;
  logic [D-1:0] push_ptr = '0;
  logic [D-1:0] pop_ptr  = '0;
  logic         both_seen = 1'b0;
  always @(negedge clk) begin
    if (stk_push) begin push_cnt++; push_ptr = stk_pointer; end
    if (stk_pop)  begin pop_cnt++;  pop_ptr  = stk_pointer; end
    if (stk_push && stk_pop) both_seen = 1'b1;
  end

  // driver tasks
  task automatic send_req(input logic op, input logic [W-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({stk_push, stk_pop} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {stk_push, stk_pop}); end
    checks++; if ({ovf_sticky, unf_sticky} !== 2'b00) begin errors++; $display("FAIL reset_sticky got=%b exp=00", {ovf_sticky, unf_sticky}); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_push();
    logic [W-1:0] vals [2];
    int lat;
    vals[0] = 8'hA5;
    vals[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      send_req(1'b1, vals[i]);
      wait_rsp(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL push%0d_latency got=%0d exp=2", i, lat); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL push%0d_err got=%b exp=0", i, bus.rsp_err); end
      checks++; if (push_ptr !== 2'(i)) begin errors++; $display("FAIL push%0d_pointer got=%0d exp=%0d", i, push_ptr, i); end
      take_rsp();
      checks++; if (count !== 2'(i + 1)) begin errors++; $display("FAIL push%0d_count got=%0d exp=%0d", i, count, i + 1); end
    end
  endtask

  task automatic test_pop();
    logic [W-1:0] exp_d [2];
    logic [D-1:0] exp_p [2];
    int lat;
    exp_d[0] = 8'h3C; exp_p[0] = 2'd0;
    exp_d[1] = 8'hA5; exp_p[1] = 2'd3;
    for (int i = 0; i < 2; i++) begin
      send_req(1'b0, '0);
      wait_rsp(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL pop%0d_latency got=%0d exp=3", i, lat); end
      checks++; if (bus.rsp_data !== exp_d[i]) begin errors++; $display("FAIL pop%0d_data got=%h exp=%h", i, bus.rsp_data, exp_d[i]); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL pop%0d_err got=%b exp=0", i, bus.rsp_err); end
      checks++; if (pop_ptr !== exp_p[i]) begin errors++; $display("FAIL pop%0d_pointer got=%0d exp=%0d", i, pop_ptr, exp_p[i]); end
      take_rsp();
      checks++; if (count !== 2'(1 - i)) begin errors++; $display("FAIL pop%0d_count got=%0d exp=%0d", i, count, 1 - i); end
    end
  endtask

  task automatic test_errors();
    int lat;
    int pops0, pushes0;
    pops0 = pop_cnt;
    send_req(1'b0, '0);
    wait_rsp(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL underflow_latency got=%0d exp=1", lat); end
    checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 8'h00}) begin errors++; $display("FAIL underflow_rsp got=%b/%h exp=1/00", bus.rsp_err, bus.rsp_data); end
    checks++; if (unf_sticky !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", unf_sticky); end
    take_rsp();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", count); end
    checks++; if (pop_cnt !== pops0) begin errors++; $display("FAIL underflow_no_pop got=%0d exp=%0d", pop_cnt, pops0); end
    send_req(1'b1, 8'h11); wait_rsp(lat); take_rsp();
    send_req(1'b1, 8'h22); wait_rsp(lat); take_rsp();
    pushes0 = push_cnt;
    send_req(1'b1, 8'h99);
    wait_rsp(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL overflow_latency got=%0d exp=1", lat); end
    checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 8'h00}) begin errors++; $display("FAIL overflow_rsp got=%b/%h exp=1/00", bus.rsp_err, bus.rsp_data); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", ovf_sticky); end
    take_rsp();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL overflow_count got=%0d exp=2", count); end
    checks++; if (push_cnt !== pushes0) begin errors++; $display("FAIL overflow_no_push got=%0d exp=%0d", push_cnt, pushes0); end
  endtask

  task automatic test_stall();
    int lat;
    int pushes0;
    send_req(1'b0, '0);
    wait_rsp(lat);
    pushes0 = push_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_data  = 8'h77;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err} !== {1'b1, 8'h22, 1'b0})
        begin errors++; $display("FAIL stall%0d_rsp got=%b/%h/%b exp=1/22/0", c, bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_req_ready got=%b exp=0", c, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    checks++; if ({count, push_cnt == pushes0} !== {2'd1, 1'b1}) begin errors++; $display("FAIL stall_no_accept count=%0d pushes=%0d exp=1/%0d", count, push_cnt, pushes0); end
    take_rsp();
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL stall_release got=%b exp=01", {bus.rsp_valid, bus.req_ready}); end
  endtask

  task automatic test_reset_mid();
    int lat;
    send_req(1'b0, '0);
    @(posedge clk); #1;
    checks++; if (dbg_state !== S_CAPT) begin errors++; $display("FAIL mid_in_capt got=%0d exp=%0d", dbg_state, S_CAPT); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({dbg_state, count, bus.rsp_valid, bus.req_ready} !== {S_IDLE, 2'd0, 1'b0, 1'b1})
      begin errors++; $display("FAIL mid_reset got=%0d/%0d/%b/%b exp=0/0/0/1", dbg_state, count, bus.rsp_valid, bus.req_ready); end
    checks++; if ({ovf_sticky, unf_sticky} !== 2'b00) begin errors++; $display("FAIL mid_reset_sticky got=%b exp=00", {ovf_sticky, unf_sticky}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got=%b exp=0", bus.rsp_valid); end
    send_req(1'b1, 8'h5A);
    wait_rsp(lat);
    checks++; if ({lat == 2, bus.rsp_err, push_ptr} !== {1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL mid_push lat=%0d err=%b ptr=%0d exp=2/0/0", lat, bus.rsp_err, push_ptr); end
    take_rsp();
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL mid_push_count got=%0d exp=1", count); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send_req(1'b1, 8'hC3); wait_rsp(lat); take_rsp();
    send_req(1'b0, '0);
    wait_rsp(lat);
    checks++; if (bus.rsp_data !== 8'hC3) begin errors++; $display("FAIL b2b_pop_top got=%h exp=c3", bus.rsp_data); end
    take_rsp();
    send_req(1'b0, '0);
    wait_rsp(lat);
    checks++; if (bus.rsp_data !== 8'h5A) begin errors++; $display("FAIL b2b_pop_bottom got=%h exp=5a", bus.rsp_data); end
    take_rsp();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL strobes_exclusive got=%b exp=0", both_seen); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_push();
    test_pop();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
